// File: rtl/conv_pkg.sv
// conv_pkg: shared helpers and types for the streaming convolution PE.
//   clog2     : ceiling log2 usable in constant expressions (clog2(1) = 0).
//   acc_width : result width of a KxK dot product of two DATA_W signed
//               operands, 2*DATA_W + clog2(K*K), so no sum can overflow.
//   pixel_t / weight_t / acc_t : signed types for the default build
//               (DATA_W = 8, K = 3).
package conv_pkg;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  function automatic int acc_width(input int data_w, input int k);
    return 2 * data_w + clog2(k * k);
  endfunction

  localparam int DEF_DATA_W = 8;
  localparam int DEF_K      = 3;
  localparam int DEF_ACC_W  = acc_width(DEF_DATA_W, DEF_K);

  typedef logic signed [DEF_DATA_W-1:0] pixel_t;
  typedef logic signed [DEF_DATA_W-1:0] weight_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: DEPTH-entry shift delay line holding one feature-map row.
// The output is the sample pushed DEPTH shifts ago, i.e. the pixel directly
// above the one currently being pushed.
//   clk  : clock, rising edge
//   en   : shift enable (one accepted pixel)
//   din  : pixel entering the line
//   dout : pixel leaving the line (DEPTH shifts old)
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] taps [DEPTH];

  // NOTE: the storage has no reset on purpose; stale contents are never
  // consumed because the window-valid logic masks every position that could
  // see them, and leaving it out keeps this a plain shift register / SRL.
  always_ff @(posedge clk) begin
    if (en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/conv_pe_stream.sv
// conv_pe_stream: streaming KxK 2-D convolution processing element.
// Consumes a FM_H x FM_W signed feature map row-major, one pixel per beat,
// and emits one signed dot product per valid window position (step STRIDE).
// Result appears the cycle after the pixel that completes its window.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_px_valid/o_px_ready: pixel handshake, i_px_data pixel
//   i_w_load, i_w_data   : weight write into the shadow bank, auto-indexed
//   o_valid/i_ready      : result handshake, o_data result, o_last end of frame
// Build option: define CONV_PE_RELU_EN to clamp negative results to zero
// inside the output register (no added latency).
module conv_pe_stream
  import conv_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int K      = 3,
  parameter  int FM_W   = 8,
  parameter  int FM_H   = 8,
  parameter  int STRIDE = 1,
  localparam int ACC_W  = acc_width(DATA_W, K)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_px_valid,
  output logic              o_px_ready,
  input  logic [DATA_W-1:0] i_px_data,
  input  logic              i_w_load,
  input  logic [DATA_W-1:0] i_w_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ACC_W-1:0]  o_data,
  output logic              o_last
);

  localparam int NW    = K * K;
  localparam int IDX_W = (NW > 1) ? clog2(NW) : 1;
  localparam int CNT_W = clog2(((FM_W > FM_H) ? FM_W : FM_H) + 1);
  localparam int PH_W  = clog2(STRIDE + 1);

  localparam logic [CNT_W-1:0] COL_MAX  = CNT_W'(FM_W - 1);
  localparam logic [CNT_W-1:0] ROW_MAX  = CNT_W'(FM_H - 1);
  localparam logic [CNT_W-1:0] K_M1     = CNT_W'(K - 1);
  // Bottom-right corner of the last window that fits on the stride grid.
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(K - 1 + ((FM_W - K) / STRIDE) * STRIDE);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(K - 1 + ((FM_H - K) / STRIDE) * STRIDE);
  localparam logic [PH_W-1:0]  PH_MAX   = PH_W'(STRIDE - 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NW - 1);

  logic [CNT_W-1:0] row, col;
  logic [PH_W-1:0]  row_ph, col_ph;   // (pos - K + 1) % STRIDE, tracked incrementally
  logic [IDX_W-1:0] w_idx;

  logic signed [DATA_W-1:0] w_shadow [NW];
  logic signed [DATA_W-1:0] w_active [NW];
  logic signed [DATA_W-1:0] win      [K][K];
  logic signed [DATA_W-1:0] win_next [K][K];

  // line_tap[j] is the pixel j rows above the incoming one (j = 0: incoming).
  logic [K-1:0][DATA_W-1:0] line_tap;

  logic px_accept, win_valid, win_last, frame_idle, frame_end;
  logic signed [ACC_W-1:0] mac_sum, result;

  assign o_px_ready = !o_valid || i_ready;
  assign px_accept  = i_px_valid && o_px_ready;

  assign win_valid  = (row >= K_M1) && (col >= K_M1) && (row_ph == '0) && (col_ph == '0);
  assign win_last   = (row == ROW_LAST) && (col == COL_LAST);
  assign frame_idle = (row == '0) && (col == '0);
  assign frame_end  = px_accept && (row == ROW_MAX) && (col == COL_MAX);

  assign line_tap[0] = i_px_data;

  for (genvar j = 1; j < K; j++) begin : g_line
    conv_line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (FM_W)
    ) u_line (
      .clk  (i_clk),
      .en   (px_accept),
      .din  (line_tap[j-1]),
      .dout (line_tap[j])
    );
  end

  // Window as it will look after the current pixel is shifted in; the MAC
  // works on this so the result can be registered on the accepting edge.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_next[r][c] = win[r][c+1];
      end
      win_next[r][K-1] = line_tap[K-1-r];
    end
  end

  // NOTE: every variable written here gets a value on every path (the
  // accumulator is cleared first), so no latch can be inferred.
  always_comb begin
    mac_sum = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        mac_sum = mac_sum + ACC_W'(win_next[r][c]) * ACC_W'(w_active[r*K+c]);
      end
    end
`ifdef CONV_PE_RELU_EN
    result = mac_sum[ACC_W-1] ? '0 : mac_sum;
`else
    result = mac_sum;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (px_accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= win_next[r][c];
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement or process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row    <= '0;
      col    <= '0;
      row_ph <= '0;
      col_ph <= '0;
    end else if (px_accept) begin
      if (col == COL_MAX) begin
        col    <= '0;
        col_ph <= '0;
        if (row == ROW_MAX) begin
          row    <= '0;
          row_ph <= '0;
        end else begin
          row <= row + CNT_W'(1);
          if (row >= K_M1) row_ph <= (row_ph == PH_MAX) ? '0 : row_ph + PH_W'(1);
        end
      end else begin
        col <= col + CNT_W'(1);
        if (col >= K_M1) col_ph <= (col_ph == PH_MAX) ? '0 : col_ph + PH_W'(1);
      end
    end
  end

  // Shadow bank takes writes at any time; the active bank follows it only
  // between frames, so a frame in flight always sees one consistent set.
  // The copy reads the shadow before any write landing on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_idx <= '0;
      for (int i = 0; i < NW; i++) begin
        w_shadow[i] <= '0;
        w_active[i] <= '0;
      end
    end else begin
      if (i_w_load) begin
        w_shadow[w_idx] <= i_w_data;
        w_idx           <= (w_idx == IDX_MAX) ? '0 : w_idx + IDX_W'(1);
      end
      if (frame_idle || frame_end) begin
        for (int i = 0; i < NW; i++) begin
          w_active[i] <= w_shadow[i];
        end
      end
    end
  end

  // One-deep output stage: a new result can only load when the old one is
  // gone or leaving this cycle, which is exactly what o_px_ready guarantees.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else if (px_accept && win_valid) begin
      o_valid <= 1'b1;
      o_data  <= result;
      o_last  <= win_last;
    end else if (i_ready) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end
  end

endmodule
